// File: rtl/instr_issue_pkg.sv
// Shared opcode constants, FSM state encoding and branch-offset helper for instr_issue.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package instr_issue_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_WAIT_BR = 3'd3,
    ST_HALT    = 3'd4
  } state_e;

  // Sign-extended 16-bit word offset turned into a byte offset.
  function automatic logic [31:0] br_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/instr_issue_if.sv
// Issue-side valid/ready bus carrying one instruction word with its opcode and pc.
// Latency: n/a (wires only).
// Backpressure: payload is held by the master while instr_valid & !instr_ready.
interface instr_issue_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [31:0] pc;

  modport master (output instr_valid, output instr, output opcode, output pc, input instr_ready);
  modport slave  (input instr_valid, input instr, input opcode, input pc, output instr_ready);
endinterface

// File: rtl/instr_issue_imem.sv
// Instruction memory: DEPTH x 32, one write port, one registered read port, contents not reset.
// Latency: read data appears the cycle after re is sampled.
// Backpressure: none; rdata holds its last value while re is low.
module imem_sync #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_q, rdata_d;

  // Read register only advances when a fetch asks for it, so issued data stays stable.
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[raddr];
  end

  // Memory write and read register; deliberately no reset so programs survive a reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/instr_issue.sv
// Instruction issuer: steps a pc through imem, issues words over valid/ready, resolves beq, stops on halt.
// Latency: start sampled -> instr_valid two edges later; one instruction per 2 cycles at best.
// Backpressure: instr/opcode/pc held in ISSUE until instr_ready; optional counter under ISSUE_COUNT_EN.
module instr_issue
  import instr_issue_pkg::*;
#(
  parameter int IMEM_DEPTH = 64,
  parameter int AW         = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              load_we,
  input  logic [AW-1:0]     load_addr,
  input  logic [31:0]       load_data,
  instr_issue_if.master     iss,
  input  logic              br_valid,
  input  logic              br_taken,
  output logic              halted,
  output logic [31:0]       issue_count
);
  localparam logic [31:0] PC_MASK = 32'(4 * IMEM_DEPTH - 1) & ~32'd3;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [15:0] imm_q, imm_d;
  logic [31:0] rdata;
  logic        mem_we, mem_re, issue_hs, is_halt_word;

  assign mem_we = load_we && (state_q == ST_IDLE || state_q == ST_HALT);
  assign mem_re = (state_q == ST_FETCH);

  imem_sync #(.DEPTH(IMEM_DEPTH), .AW(AW)) u_imem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (load_addr),
    .wdata (load_data),
    .re    (mem_re),
    .raddr (pc_q[AW+1:2]),
    .rdata (rdata)
  );

  // The fetched word is visible in ISSUE; a halt word is never presented as valid.
  assign is_halt_word    = (rdata[31:26] == OP_HALT);
  assign iss.instr_valid = (state_q == ST_ISSUE) && !is_halt_word;
  assign iss.instr       = (state_q == ST_ISSUE) ? rdata : 32'd0;
  assign iss.opcode      = iss.instr[31:26];
  assign iss.pc          = pc_q;
  assign issue_hs        = iss.instr_valid && iss.instr_ready;
  assign halted          = (state_q == ST_HALT);

  // Next-state, pc and branch-immediate selection.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    imm_d   = imm_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_FETCH;
      ST_FETCH: state_d = ST_ISSUE;
      ST_ISSUE: begin
        if (is_halt_word) begin
          state_d = ST_HALT;
        end else if (issue_hs) begin
          if (rdata[31:26] == OP_BEQ) begin
            state_d = ST_WAIT_BR;
            imm_d   = rdata[15:0];
          end else begin
            state_d = ST_FETCH;
            pc_d    = (pc_q + 32'd4) & PC_MASK;
          end
        end
      end
      ST_WAIT_BR: begin
        if (br_valid) begin
          state_d = ST_FETCH;
          pc_d    = (pc_q + 32'd4 + (br_taken ? br_offset(imm_q) : 32'd0)) & PC_MASK;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset overrides any same-cycle handshake or branch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= 32'd0;
      imm_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      imm_q   <= imm_d;
    end
  end

`ifdef ISSUE_COUNT_EN
  logic [31:0] cnt_q, cnt_d;

  // Count accepted instructions, wrapping naturally at 2^32.
  always_comb begin
    cnt_d = cnt_q;
    if (issue_hs) cnt_d = cnt_q + 32'd1;
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= 32'd0;
    else       cnt_q <= cnt_d;
  end

  assign issue_count = cnt_q;
`else
  assign issue_count = 32'd0;
`endif

endmodule
